mutex_rule_scheduler: RTL

// - Drives the rule-enable vector io_en_a of the generated Murphi "system" (mutual-exclusion model) from hardware, not from a bench.
// - Samples the system's rule guards, picks one enabled rule round-robin, fires it for exactly one cycle, and repeats until a step budget runs out or no guard holds (deadlock).
// - Sits between the run controller and the system, for self-driven simulation and equivalence runs.

---
 rtl/mutex_rule_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mutex_rule_scheduler.sv
// mutex_rule_scheduler: drives the rule-enable vector of the Murphi mutual
// exclusion "system" from hardware. Each step samples the rule guards, picks
// one enabled rule and fires it for exactly one cycle, until the step budget
// is used up or no guard holds.
//
// Optional feature macro: SCHED_RANDOM_EN
//   defined   - the search start index comes from a free-running 16-bit
//               Galois LFSR (seed 16'hACE1), exposed on io_lfsr_state
//   undefined - pure round-robin search from rr_ptr
//
// Handshake: io_start is a level request that is only looked at in IDLE; a
// start seen there is accepted on that clock edge. io_abort is a level
// request honoured in SAMPLE and FIRE and ignored in IDLE. There is no
// back-pressure: the system must act on io_en_a in the single FIRE cycle.
module mutex_rule_scheduler #(
    parameter int NUM_RULES = 4,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_abort,
    input  logic [CNT_W-1:0]     io_budget,
    input  logic [NUM_RULES-1:0] io_guard,
    output logic [NUM_RULES-1:0] io_en_a,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_deadlock,
    output logic [CNT_W-1:0]     io_fired_count,
    output logic [IDX_W-1:0]     io_last_rule,
`ifdef SCHED_RANDOM_EN
    output logic [15:0]          io_lfsr_state,
`endif
    output logic [1:0]           io_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        FIRE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_RULES-1:0]   en_q, en_d;
    logic                   done_q, done_d;
    logic                   dead_q, dead_d;
    logic [CNT_W-1:0]       fired_q, fired_d;
    logic [CNT_W-1:0]       budget_q, budget_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [IDX_W-1:0]       chosen_q, chosen_d;
    logic [IDX_W-1:0]       search_start;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;

`ifdef SCHED_RANDOM_EN
    logic [15:0]            lfsr_q;

    // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1, advances every clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign search_start  = lfsr_q[IDX_W-1:0];
    assign io_lfsr_state = lfsr_q;
`else
    logic [IDX_W-1:0]       rr_q, rr_d;

    // Round-robin pointer: one past the last fired rule, survives between runs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Pointer advances only when a FIRE cycle completes (aborted or not).
    always_comb begin
        rr_d = rr_q;
        if (state_q == FIRE) begin
            if (chosen_q == IDX_W'(NUM_RULES - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = chosen_q + IDX_W'(1);
            end
        end
    end

    assign search_start = rr_q;
`endif

    // First set guard bit at or after search_start, wrapping modulo NUM_RULES.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_RULES; k++) begin
            idx = (int'(search_start) + k) % NUM_RULES;
            if (!pick_found && io_guard[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    // State and output registers; everything the system sees is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= '0;
            done_q   <= 1'b0;
            dead_q   <= 1'b0;
            fired_q  <= '0;
            budget_q <= '0;
            last_q   <= '0;
            chosen_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            done_q   <= done_d;
            dead_q   <= dead_d;
            fired_q  <= fired_d;
            budget_q <= budget_d;
            last_q   <= last_d;
            chosen_q <= chosen_d;
        end
    end

    // Next-state logic; the enable is zero unless SAMPLE is launching a FIRE.
    always_comb begin
        state_d  = state_q;
        en_d     = '0;
        done_d   = done_q;
        dead_d   = dead_q;
        fired_d  = fired_q;
        budget_d = budget_q;
        last_d   = last_q;
        chosen_d = chosen_q;
        case (state_q)
            IDLE: begin
                if (io_start) begin
                    budget_d = io_budget;
                    done_d   = 1'b0;
                    dead_d   = 1'b0;
                    fired_d  = '0;
                    if (io_budget == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                if (io_abort) begin
                    state_d = IDLE;
                end else if (pick_found) begin
                    en_d     = NUM_RULES'(1) << pick_idx;
                    chosen_d = pick_idx;
                    state_d  = FIRE;
                end else begin
                    dead_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            FIRE: begin
                // The enable was already driven this cycle, so the fire counts
                // even when an abort arrives alongside it.
                fired_d = fired_q + CNT_W'(1);
                last_d  = chosen_q;
                if (io_abort) begin
                    state_d = IDLE;
                end else if (fired_q + CNT_W'(1) == budget_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SAMPLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign io_en_a        = en_q;
    assign io_busy        = (state_q != IDLE);
    assign io_done        = done_q;
    assign io_deadlock    = dead_q;
    assign io_fired_count = fired_q;
    assign io_last_rule   = last_q;
    assign io_state       = state_q;

endmodule
